// File: rtl/serial_compare_32.sv
// Multi-cycle MSB-first magnitude comparator: CHUNK bits per cycle with early exit,
// unsigned or two's-complement. Reports one of eq/lt/gt with a one-cycle done pulse.
module serial_compare_32 #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_cmp,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             lt,
  output logic             gt
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             eq_q, eq_d, lt_q, lt_d, gt_q, gt_d;
  logic             busy_q, done_q;
  logic [WIDTH-1:0] msb_flip;
  logic [CHUNK-1:0] a_chunk, b_chunk;

  // Inverting the sign bit of both operands turns a signed compare into an unsigned one.
  assign msb_flip = {signed_cmp, {(WIDTH-1){1'b0}}};
  assign a_chunk  = a_q[CHUNK*idx_q +: CHUNK];
  assign b_chunk  = b_q[CHUNK*idx_q +: CHUNK];

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    gt_d    = gt_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a ^ msb_flip;
          b_d     = b ^ msb_flip;
          idx_d   = IW'(NCHUNK - 1);
          eq_d    = 1'b0;
          lt_d    = 1'b0;
          gt_d    = 1'b0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (a_chunk > b_chunk) begin
          gt_d    = 1'b1;
          state_d = DONE;
        end else if (a_chunk < b_chunk) begin
          lt_d    = 1'b1;
          state_d = DONE;
        end else if (idx_q == '0) begin
          eq_d    = 1'b1;
          state_d = DONE;
        end else begin
          idx_d   = idx_q - IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
      busy_q  <= (state_d == RUN);
      done_q  <= (state_d == DONE);
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign eq   = eq_q;
  assign lt   = lt_q;
  assign gt   = gt_q;

endmodule
